reg_access_ctrl: RTL and testbench
==================================

# reg_access_ctrl

Sequences host register accesses decoded by the bus front-end into 16-bit register-file transactions. It sits between the bus front-end and the register/VRAM arbiter. It assembles byte writes into words and fetches and caches words for byte reads. It runs a req/ack handshake with the arbiter and drives the DTACK level that the front-end forwards to the host, with a timeout so the host bus can never hang.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum number of cycles a request is held waiting for `reg_ack_i` (range 2..255).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- write_strobe_i  in  1  one-cycle pulse: host byte write.
- read_strobe_i  in  1  one-cycle pulse: host byte read.
- reg_num_i  in  4  register number, valid with a strobe.
- bytesel_i  in  1  0 = even (high) byte, 1 = odd (low) byte.
- bytedata_i  in  8  write byte, valid with `write_strobe_i`.
- bus_data_o  out  8  read byte returned to the host.
- dtack_o  out  1  DTACK level to the front-end, using the `xv::DTACK_ACK` / `xv::DTACK_NAK` encodings.
- reg_wr_o  out  1  register write request (level).
- reg_rd_o  out  1  register read request (level).
- reg_addr_o  out  4  register number of the pending request.
- reg_wdata_o  out  16  write word, `{even_byte, odd_byte}`.
- reg_ack_i  in  1  arbiter acknowledge; one-cycle pulse.
- reg_rdata_i  in  16  read word, valid with `reg_ack_i`.
- timeout_o  out  1  one-cycle pulse: request aborted on timeout.
- overrun_o  out  1  one-cycle pulse: strobe dropped because the block was busy.

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT.
- Strobes are accepted only in IDLE.
  - An accepted strobe sets `dtack_o` to NAK in the same edge.
  - If both strobes arrive together, the write wins and the read is ignored; no overrun is flagged.
- Even write (`bytesel_i` = 0): latch `bytedata_i` into `hi_byte`. No request is issued; `dtack_o` becomes ACK on the next edge. The FSM stays in IDLE.
- Odd write: drive `reg_wdata_o` = `{hi_byte, bytedata_i}` and `reg_addr_o` = `reg_num_i`, assert `reg_wr_o`, go to WR_WAIT.
  - Any accepted write to register R with a valid cache tag of R invalidates the cache.
- Even read: assert `reg_rd_o` with `reg_addr_o` = `reg_num_i`, go to RD_WAIT.
- Odd read:
  - Cache hit (cache valid and tag == `reg_num_i`): `bus_data_o` = `cache[7:0]`, ACK next edge, no request.
  - Miss: issue a read as for an even read.
- WR_WAIT / RD_WAIT on `reg_ack_i`:
  - Drop the request and return to IDLE.
  - `dtack_o` = ACK.
  - For RD_WAIT: load `cache` = `reg_rdata_i`, tag = `reg_addr_o`, set valid; `bus_data_o` = the selected byte of `reg_rdata_i` (`bytesel` latched at strobe).
- Timeout: `wait_cnt` clears when a request is issued and increments each waiting cycle without ack.
  - If `TIMEOUT_CYCLES` waiting cycles elapse without ack: drop the request, return to IDLE, `dtack_o` = ACK, pulse `timeout_o`.
  - On a read timeout, also `bus_data_o` = 8'hFF and invalidate the cache.
  - An ack in the final waiting cycle counts as success; `timeout_o` is not pulsed.
- `dtack_o` holds ACK until the next accepted strobe. The front-end masks it whenever CS is inactive.
- A strobe while in WR_WAIT or RD_WAIT is dropped, pulses `overrun_o`, and has no other effect.
- `reg_ack_i` while in IDLE is ignored.

## Timing
- Reset values: `dtack_o` = NAK; `bus_data_o` = 8'h00; `reg_wr_o` = `reg_rd_o` = 0; `reg_addr_o` = 0; `reg_wdata_o` = 0; `timeout_o` = `overrun_o` = 0.
- Reset also clears `hi_byte`, clears the cache valid bit, and sets the FSM to IDLE.
- Asserting reset mid-request drops `reg_wr_o` / `reg_rd_o` immediately (asynchronously); no ack is awaited after release.
- Strobe sampled at edge N:
  - Request asserted after edge N.
  - Even write / cache-hit read: `dtack_o` = ACK after edge N+1. N+1 is the first legal ack edge.
- Ack sampled at edge M: request low, `dtack_o` = ACK, and `bus_data_o` valid after edge M.
- Request high-time:
  - Minimum 1 cycle.
  - Maximum `TIMEOUT_CYCLES` cycles; the timeout pulse comes at the edge after the last waiting cycle.
- `reg_addr_o` and `reg_wdata_o` are stable for the whole time a request is high.
- `timeout_o` and `overrun_o` are exactly one cycle wide.

## Test plan
- Write 8'h12 even then 8'h34 odd to reg 3:
  - `reg_wr_o` pulses once with addr 3, wdata 16'h1234.
  - Ack after 2 cycles → `dtack_o` ACK on the ack edge.
  - The even write alone gives ACK after 1 cycle with no request.
- Even read of reg 5 with arbiter returning 16'hABCD → `bus_data_o` = 8'hAB.
  - Following odd read of reg 5 → 8'hCD with no `reg_rd_o`.
  - Odd read of reg 6 → new request.
- Read reg 5, then write reg 5 (even+odd), then odd read reg 5 → a fresh `reg_rd_o` is issued (cache invalidated).
- No ack with `TIMEOUT_CYCLES` = 4 → `reg_rd_o` high exactly 4 cycles, then `timeout_o` pulse, `dtack_o` ACK, `bus_data_o` 8'hFF.
  - Ack in the 4th waiting cycle → normal completion, no timeout pulse.
- Strobe during RD_WAIT → `overrun_o` 1-cycle pulse; request and addr unchanged.
- Assert `reset_n_i` low during WR_WAIT → `reg_wr_o` low and `dtack_o` NAK before the next clk edge.
  - After release: IDLE, cache invalid, `hi_byte` = 0.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// Host register access sequencer: assembles byte writes into 16-bit words, caches the last
// read word for odd-byte reads, and runs the req/ack handshake with a timeout-protected DTACK.
package xv;
    localparam logic DTACK_ACK = 1'b0;
    localparam logic DTACK_NAK = 1'b1;
endpackage

module reg_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        write_strobe_i,
    input  logic        read_strobe_i,
    input  logic [3:0]  reg_num_i,
    input  logic        bytesel_i,
    input  logic [7:0]  bytedata_i,
    output logic [7:0]  bus_data_o,
    output logic        dtack_o,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    output logic [3:0]  reg_addr_o,
    output logic [15:0] reg_wdata_o,
    input  logic        reg_ack_i,
    input  logic [15:0] reg_rdata_i,
    output logic        timeout_o,
    output logic        overrun_o
);
    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [7:0]  hi_byte_reg;
    logic [15:0] cache_reg;
    logic [3:0]  cache_tag_reg;
    logic        cache_valid_reg;
    logic        bytesel_reg;
    logic [7:0]  wait_cnt_reg;
    logic        ack_pending_reg;

    logic strobe;
    logic cache_hit;

    assign strobe    = write_strobe_i | read_strobe_i;
    assign cache_hit = cache_valid_reg && (cache_tag_reg == reg_num_i);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg       <= IDLE;
            hi_byte_reg     <= 8'h00;
            cache_reg       <= 16'h0000;
            cache_tag_reg   <= 4'h0;
            cache_valid_reg <= 1'b0;
            bytesel_reg     <= 1'b0;
            wait_cnt_reg    <= 8'h00;
            ack_pending_reg <= 1'b0;
            bus_data_o      <= 8'h00;
            dtack_o         <= xv::DTACK_NAK;
            reg_wr_o        <= 1'b0;
            reg_rd_o        <= 1'b0;
            reg_addr_o      <= 4'h0;
            reg_wdata_o     <= 16'h0000;
            timeout_o       <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            overrun_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Write has priority over a simultaneous read; the read is silently dropped.
                    if (write_strobe_i) begin
                        dtack_o <= xv::DTACK_NAK;
                        if (cache_hit) cache_valid_reg <= 1'b0;
                        if (!bytesel_i) begin
                            hi_byte_reg     <= bytedata_i;
                            ack_pending_reg <= 1'b1;
                        end else begin
                            reg_wdata_o     <= {hi_byte_reg, bytedata_i};
                            reg_addr_o      <= reg_num_i;
                            reg_wr_o        <= 1'b1;
                            wait_cnt_reg    <= 8'h00;
                            ack_pending_reg <= 1'b0;
                            state_reg       <= WR_WAIT;
                        end
                    end else if (read_strobe_i) begin
                        dtack_o     <= xv::DTACK_NAK;
                        bytesel_reg <= bytesel_i;
                        if (bytesel_i && cache_hit) begin
                            bus_data_o      <= cache_reg[7:0];
                            ack_pending_reg <= 1'b1;
                        end else begin
                            reg_addr_o      <= reg_num_i;
                            reg_rd_o        <= 1'b1;
                            wait_cnt_reg    <= 8'h00;
                            ack_pending_reg <= 1'b0;
                            state_reg       <= RD_WAIT;
                        end
                    end else if (ack_pending_reg) begin
                        dtack_o         <= xv::DTACK_ACK;
                        ack_pending_reg <= 1'b0;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (strobe) overrun_o <= 1'b1;
                    if (reg_ack_i) begin
                        reg_wr_o  <= 1'b0;
                        reg_rd_o  <= 1'b0;
                        dtack_o   <= xv::DTACK_ACK;
                        state_reg <= IDLE;
                        if (state_reg == RD_WAIT) begin
                            cache_reg       <= reg_rdata_i;
                            cache_tag_reg   <= reg_addr_o;
                            cache_valid_reg <= 1'b1;
                            bus_data_o      <= bytesel_reg ? reg_rdata_i[7:0] : reg_rdata_i[15:8];
                        end
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        reg_wr_o  <= 1'b0;
                        reg_rd_o  <= 1'b0;
                        dtack_o   <= xv::DTACK_ACK;
                        timeout_o <= 1'b1;
                        state_reg <= IDLE;
                        if (state_reg == RD_WAIT) begin
                            bus_data_o      <= 8'hFF;
                            cache_valid_reg <= 1'b0;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a 4-cycle timeout; arbiter acks are driven by hand.
module tb_reg_access_ctrl;
    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        write_strobe_i, read_strobe_i;
    logic [3:0]  reg_num_i;
    logic        bytesel_i;
    logic [7:0]  bytedata_i;
    logic [7:0]  bus_data_o;
    logic        dtack_o, reg_wr_o, reg_rd_o;
    logic [3:0]  reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic        reg_ack_i;
    logic [15:0] reg_rdata_i;
    logic        timeout_o, overrun_o;

    int checks = 0;
    int passed = 0;

    localparam logic ACK = xv::DTACK_ACK;
    localparam logic NAK = xv::DTACK_NAK;

    reg_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .write_strobe_i(write_strobe_i), .read_strobe_i(read_strobe_i),
        .reg_num_i(reg_num_i), .bytesel_i(bytesel_i), .bytedata_i(bytedata_i),
        .bus_data_o(bus_data_o), .dtack_o(dtack_o),
        .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i),
        .timeout_o(timeout_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Present a strobe for exactly one sampling edge; returns 1ns after that edge.
    task automatic do_strobe(input logic wr, input logic rd, input logic [3:0] r,
                             input logic sel, input logic [7:0] d);
        write_strobe_i = wr; read_strobe_i = rd;
        reg_num_i = r; bytesel_i = sel; bytedata_i = d;
        @(posedge clk); #1;
        write_strobe_i = 1'b0; read_strobe_i = 1'b0;
        $display("strobe wr=%0b rd=%0b reg=%0d sel=%0b data=%h", wr, rd, r, sel, d);
    endtask

    task automatic do_ack(input logic [15:0] data);
        reg_ack_i = 1'b1; reg_rdata_i = data;
        @(posedge clk); #1;
        reg_ack_i = 1'b0;
        $display("ack rdata=%h", data);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++; if (dtack_o !== NAK) $display("FAIL rst_dtack got %b want %b", dtack_o, NAK); else passed++;
        checks++; if (bus_data_o !== 8'h00) $display("FAIL rst_bus got %h want 00", bus_data_o); else passed++;
        checks++; if ({reg_wr_o, reg_rd_o} !== 2'b00) $display("FAIL rst_req got %b want 00", {reg_wr_o, reg_rd_o}); else passed++;
        checks++; if (reg_addr_o !== 4'h0) $display("FAIL rst_addr got %h want 0", reg_addr_o); else passed++;
        checks++; if (reg_wdata_o !== 16'h0000) $display("FAIL rst_wdata got %h want 0000", reg_wdata_o); else passed++;
        checks++; if ({timeout_o, overrun_o} !== 2'b00) $display("FAIL rst_pulses got %b want 00", {timeout_o, overrun_o}); else passed++;
    endtask

    task automatic test_write;
        do_strobe(1, 0, 4'd3, 1'b0, 8'h12);
        checks++; if (dtack_o !== NAK) $display("FAIL even_wr_nak got %b want %b", dtack_o, NAK); else passed++;
        checks++; if (reg_wr_o !== 1'b0) $display("FAIL even_wr_noreq got %b want 0", reg_wr_o); else passed++;
        tick();
        checks++; if (dtack_o !== ACK) $display("FAIL even_wr_ack got %b want %b", dtack_o, ACK); else passed++;
        checks++; if (reg_wr_o !== 1'b0) $display("FAIL even_wr_noreq2 got %b want 0", reg_wr_o); else passed++;
        do_strobe(1, 0, 4'd3, 1'b1, 8'h34);
        checks++; if ({reg_wr_o, reg_addr_o, reg_wdata_o} !== {1'b1, 4'd3, 16'h1234})
            $display("FAIL odd_wr_req got wr=%b addr=%h wdata=%h want 1 3 1234", reg_wr_o, reg_addr_o, reg_wdata_o); else passed++;
        checks++; if (dtack_o !== NAK) $display("FAIL odd_wr_nak got %b want %b", dtack_o, NAK); else passed++;
        tick();
        checks++; if (reg_wr_o !== 1'b1) $display("FAIL odd_wr_hold got %b want 1", reg_wr_o); else passed++;
        do_ack(16'h0000);
        checks++; if ({reg_wr_o, dtack_o, timeout_o} !== {1'b0, ACK, 1'b0})
            $display("FAIL odd_wr_done got wr=%b dtack=%b to=%b want 0 %b 0", reg_wr_o, dtack_o, timeout_o, ACK); else passed++;
        tick();
        checks++; if ({reg_wr_o, dtack_o} !== {1'b0, ACK}) $display("FAIL odd_wr_once got wr=%b dtack=%b", reg_wr_o, dtack_o); else passed++;
    endtask

    task automatic test_read_cache;
        do_strobe(0, 1, 4'd5, 1'b0, 8'h00);
        checks++; if ({reg_rd_o, reg_addr_o} !== {1'b1, 4'd5}) $display("FAIL rd5_req got rd=%b addr=%h want 1 5", reg_rd_o, reg_addr_o); else passed++;
        tick();
        do_ack(16'hABCD);
        checks++; if ({reg_rd_o, dtack_o, bus_data_o} !== {1'b0, ACK, 8'hAB})
            $display("FAIL rd5_even got rd=%b dtack=%b data=%h want 0 %b AB", reg_rd_o, dtack_o, bus_data_o, ACK); else passed++;
        do_strobe(0, 1, 4'd5, 1'b1, 8'h00);
        checks++; if ({reg_rd_o, dtack_o} !== {1'b0, NAK}) $display("FAIL rd5_hit_nak got rd=%b dtack=%b", reg_rd_o, dtack_o); else passed++;
        tick();
        checks++; if ({reg_rd_o, dtack_o, bus_data_o} !== {1'b0, ACK, 8'hCD})
            $display("FAIL rd5_hit got rd=%b dtack=%b data=%h want 0 %b CD", reg_rd_o, dtack_o, bus_data_o, ACK); else passed++;
        do_strobe(0, 1, 4'd6, 1'b1, 8'h00);
        checks++; if ({reg_rd_o, reg_addr_o} !== {1'b1, 4'd6}) $display("FAIL rd6_miss got rd=%b addr=%h want 1 6", reg_rd_o, reg_addr_o); else passed++;
        do_ack(16'h5678);
        checks++; if ({reg_rd_o, bus_data_o} !== {1'b0, 8'h78}) $display("FAIL rd6_data got rd=%b data=%h want 0 78", reg_rd_o, bus_data_o); else passed++;
    endtask

    task automatic test_invalidate;
        do_strobe(0, 1, 4'd5, 1'b0, 8'h00);
        do_ack(16'hABCD);
        checks++; if (bus_data_o !== 8'hAB) $display("FAIL inv_rd got %h want AB", bus_data_o); else passed++;
        do_strobe(1, 0, 4'd5, 1'b0, 8'h11);
        tick();
        do_strobe(1, 0, 4'd5, 1'b1, 8'h22);
        checks++; if (reg_wdata_o !== 16'h1122) $display("FAIL inv_wdata got %h want 1122", reg_wdata_o); else passed++;
        do_ack(16'h0000);
        do_strobe(0, 1, 4'd5, 1'b1, 8'h00);
        checks++; if ({reg_rd_o, reg_addr_o} !== {1'b1, 4'd5}) $display("FAIL inv_refetch got rd=%b addr=%h want 1 5", reg_rd_o, reg_addr_o); else passed++;
        do_ack(16'h1122);
        checks++; if (bus_data_o !== 8'h22) $display("FAIL inv_data got %h want 22", bus_data_o); else passed++;
    endtask

    task automatic test_timeout;
        do_strobe(0, 1, 4'd9, 1'b0, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if ({reg_rd_o, timeout_o} !== 2'b10) $display("FAIL to_wait%0d got rd=%b to=%b want 1 0", k, reg_rd_o, timeout_o); else passed++;
        end
        tick();
        checks++; if ({reg_rd_o, timeout_o, dtack_o, bus_data_o} !== {1'b0, 1'b1, ACK, 8'hFF})
            $display("FAIL to_fire got rd=%b to=%b dtack=%b data=%h want 0 1 %b FF", reg_rd_o, timeout_o, dtack_o, bus_data_o, ACK); else passed++;
        tick();
        checks++; if (timeout_o !== 1'b0) $display("FAIL to_width got %b want 0", timeout_o); else passed++;
    endtask

    task automatic test_ack_last;
        // Cache for reg 5 was dropped by the read timeout, so this odd read must fetch.
        do_strobe(0, 1, 4'd5, 1'b1, 8'h00);
        checks++; if (reg_rd_o !== 1'b1) $display("FAIL last_refetch got %b want 1", reg_rd_o); else passed++;
        tick(); tick(); tick();
        checks++; if (reg_rd_o !== 1'b1) $display("FAIL last_hold got %b want 1", reg_rd_o); else passed++;
        do_ack(16'hBEEF);
        checks++; if ({reg_rd_o, timeout_o, dtack_o, bus_data_o} !== {1'b0, 1'b0, ACK, 8'hEF})
            $display("FAIL last_ack got rd=%b to=%b dtack=%b data=%h want 0 0 %b EF", reg_rd_o, timeout_o, dtack_o, bus_data_o, ACK); else passed++;
        tick();
        checks++; if (timeout_o !== 1'b0) $display("FAIL last_noto got %b want 0", timeout_o); else passed++;
    endtask

    task automatic test_overrun;
        do_strobe(0, 1, 4'd7, 1'b0, 8'h00);
        do_strobe(1, 0, 4'd2, 1'b1, 8'h55);
        checks++; if ({overrun_o, reg_rd_o, reg_wr_o, reg_addr_o} !== {1'b1, 1'b1, 1'b0, 4'd7})
            $display("FAIL ovr_pulse got ovr=%b rd=%b wr=%b addr=%h want 1 1 0 7", overrun_o, reg_rd_o, reg_wr_o, reg_addr_o); else passed++;
        tick();
        checks++; if ({overrun_o, reg_rd_o} !== 2'b01) $display("FAIL ovr_width got ovr=%b rd=%b want 0 1", overrun_o, reg_rd_o); else passed++;
        do_ack(16'h7A7B);
        checks++; if (bus_data_o !== 8'h7A) $display("FAIL ovr_data got %h want 7A", bus_data_o); else passed++;
    endtask

    task automatic test_both_strobes;
        do_strobe(1, 1, 4'd1, 1'b0, 8'h99);
        checks++; if ({overrun_o, reg_rd_o, dtack_o} !== {1'b0, 1'b0, NAK})
            $display("FAIL both_first got ovr=%b rd=%b dtack=%b", overrun_o, reg_rd_o, dtack_o); else passed++;
        tick();
        checks++; if (dtack_o !== ACK) $display("FAIL both_ack got %b want %b", dtack_o, ACK); else passed++;
        do_strobe(1, 0, 4'd1, 1'b1, 8'h88);
        checks++; if (reg_wdata_o !== 16'h9988) $display("FAIL both_wdata got %h want 9988", reg_wdata_o); else passed++;
        do_ack(16'h0000);
    endtask

    task automatic test_reset_mid;
        do_strobe(1, 0, 4'd4, 1'b0, 8'h44);
        tick();
        do_strobe(1, 0, 4'd4, 1'b1, 8'h66);
        checks++; if (reg_wr_o !== 1'b1) $display("FAIL mid_req got %b want 1", reg_wr_o); else passed++;
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if ({reg_wr_o, dtack_o} !== {1'b0, NAK}) $display("FAIL mid_async got wr=%b dtack=%b want 0 %b", reg_wr_o, dtack_o, NAK); else passed++;
        @(posedge clk); #3 reset_n_i = 1'b1;
        @(posedge clk); #1;
        checks++; if ({reg_wr_o, dtack_o} !== {1'b0, NAK}) $display("FAIL mid_idle got wr=%b dtack=%b", reg_wr_o, dtack_o); else passed++;
        do_strobe(1, 0, 4'd4, 1'b1, 8'h01);
        checks++; if (reg_wdata_o !== 16'h0001) $display("FAIL mid_hibyte got %h want 0001", reg_wdata_o); else passed++;
        do_ack(16'h0000);
        do_strobe(0, 1, 4'd7, 1'b1, 8'h00);
        checks++; if (reg_rd_o !== 1'b1) $display("FAIL mid_cache got %b want 1", reg_rd_o); else passed++;
        do_ack(16'h7A7B);
        checks++; if (bus_data_o !== 8'h7B) $display("FAIL mid_data got %h want 7B", bus_data_o); else passed++;
    endtask

    initial begin
        reset_n_i = 1'b0;
        write_strobe_i = 1'b0; read_strobe_i = 1'b0;
        reg_num_i = 4'h0; bytesel_i = 1'b0; bytedata_i = 8'h00;
        reg_ack_i = 1'b0; reg_rdata_i = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        #3 reset_n_i = 1'b1;
        @(posedge clk); #1;
        test_write();
        test_read_cache();
        test_invalidate();
        test_timeout();
        test_ack_last();
        test_overrun();
        test_both_strobes();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
